timer_counter: RTL



---
 rtl/timer_counter_pkg.sv | 43 ++++
 rtl/timer_counter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the timer_counter peripheral: register offsets, FSM
// state encoding, CTRL mode codes and bit positions, plus a byte-lane merge helper.
package timer_counter_pkg;

    localparam logic [1:0] TC_OFF_CTRL   = 2'd0;
    localparam logic [1:0] TC_OFF_PRESET = 2'd1;
    localparam logic [1:0] TC_OFF_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    localparam int TC_CTRL_EN      = 0;
    localparam int TC_CTRL_MODE_LO = 1;
    localparam int TC_CTRL_MODE_HI = 2;
    localparam int TC_CTRL_IM      = 3;
    localparam int TC_CTRL_W       = 4;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] tc_merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and an irq.
// Optional macro TC_BYTE_WRITE_EN: honour individual byte enables on writes.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    tc_state_e              state_r, state_nxt_s;
    logic [TC_CTRL_W-1:0]   ctrl_r, ctrl_fsm_s, ctrl_wdata_s, ctrl_nxt_s;
    logic [31:0]            preset_r, preset_wdata_s, preset_nxt_s;
    logic [31:0]            count_r, count_nxt_s;
    logic                   irq_flag_r, flag_fsm_s, flag_nxt_s, int_set_s;
    logic                   wr_s, ctrl_wr_s, preset_wr_s;
    logic [1:0]             sel_s;
    logic                   unused_addr_s;

    assign hit           = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel_s         = addr[3:2];
    assign wr_s          = hit & (byteen != 4'b0000);
    assign ctrl_wr_s     = wr_s & (sel_s == TC_OFF_CTRL);
    assign preset_wr_s   = wr_s & (sel_s == TC_OFF_PRESET);
    assign irq           = irq_flag_r & ctrl_r[TC_CTRL_IM];
    assign unused_addr_s = ^addr[1:0];

`ifdef TC_BYTE_WRITE_EN
    assign ctrl_wdata_s   = byteen[0] ? wdata[TC_CTRL_W-1:0] : ctrl_fsm_s;
    assign preset_wdata_s = tc_merge_bytes(preset_r, wdata, byteen);
`else
    assign ctrl_wdata_s   = wdata[TC_CTRL_W-1:0];
    assign preset_wdata_s = wdata;
`endif

    // Counter FSM: next state, COUNT update and the FSM's own CTRL/flag effects.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        flag_fsm_s  = irq_flag_r;
        ctrl_fsm_s  = ctrl_r;
        int_set_s   = 1'b0;
        case (state_r)
            TC_IDLE: begin
                if (ctrl_r[TC_CTRL_EN]) begin
                    state_nxt_s = TC_LOAD;
                end else begin
                    state_nxt_s = TC_IDLE;
                end
            end
            TC_LOAD: begin
                count_nxt_s = preset_r;
                flag_fsm_s  = 1'b0;
                state_nxt_s = TC_CNT;
            end
            TC_CNT: begin
                if (!ctrl_r[TC_CTRL_EN]) begin
                    state_nxt_s = TC_IDLE;
                end else if (count_r <= 32'd1) begin
                    count_nxt_s = 32'd0;
                    flag_fsm_s  = 1'b1;
                    int_set_s   = 1'b1;
                    state_nxt_s = TC_INT;
                end else begin
                    count_nxt_s = count_r - 32'd1;
                end
            end
            TC_INT: begin
                if (ctrl_r[TC_CTRL_MODE_HI:TC_CTRL_MODE_LO] == TC_MODE_RELOAD) begin
                    state_nxt_s = TC_LOAD;
                end else begin
                    ctrl_fsm_s[TC_CTRL_EN] = 1'b0;
                    state_nxt_s            = TC_IDLE;
                end
            end
            default: begin
                state_nxt_s = TC_IDLE;
            end
        endcase
    end

    // Bus writes override the FSM's CTRL update; an interrupt raised this edge survives a CTRL write.
    always_comb begin
        ctrl_nxt_s   = ctrl_fsm_s;
        preset_nxt_s = preset_r;
        flag_nxt_s   = flag_fsm_s;
        if (ctrl_wr_s) begin
            ctrl_nxt_s = ctrl_wdata_s;
            flag_nxt_s = int_set_s;
        end else begin
            ctrl_nxt_s = ctrl_fsm_s;
        end
        if (preset_wr_s) begin
            preset_nxt_s = preset_wdata_s;
        end else begin
            preset_nxt_s = preset_r;
        end
    end

    // Read mux; reserved offset and misses read as zero.
    always_comb begin
        rdata = 32'h0000_0000;
        if (hit) begin
            case (sel_s)
                TC_OFF_CTRL:   rdata = {{(32-TC_CTRL_W){1'b0}}, ctrl_r};
                TC_OFF_PRESET: rdata = preset_r;
                TC_OFF_COUNT:  rdata = count_r;
                default:       rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= TC_IDLE;
            ctrl_r     <= {TC_CTRL_W{1'b0}};
            preset_r   <= 32'h0000_0000;
            count_r    <= 32'h0000_0000;
            irq_flag_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
            preset_r   <= preset_nxt_s;
            count_r    <= count_nxt_s;
            irq_flag_r <= flag_nxt_s;
        end
    end

endmodule
